// File: rtl/seven_seg_decoder.sv
// Registered hex-to-7-segment decoder for one display digit.
//
// Ports:
//   I_CLK        system clock, all state changes on the rising edge
//   I_RST        synchronous reset, active-high; forces the digit dark
//   IN           hex nibble to display (0x0..0xF)
//   I_BLANK      1 = all segments dark
//   I_LAMP_TEST  1 = all segments lit (wins over I_BLANK)
//   OUT          registered segment drive, OUT[0]=a .. OUT[6]=g
//
// ACTIVE_LOW selects the board polarity: 1 = a segment is lit when its bit is 0.
// OUT is driven straight from a flop, so there is no combinational input-to-output path.

module seven_seg_decoder #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       I_CLK,
  input  logic       I_RST,
  input  logic [3:0] IN,
  input  logic       I_BLANK,
  input  logic       I_LAMP_TEST,
  output logic [6:0] OUT
);

  localparam logic [6:0] AllDark = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [6:0] AllLit  = ~AllDark;

  logic [6:0] glyph_n;  // active-low glyph, bits g..a
  logic [6:0] out_d;
  logic [6:0] out_q;

  // Glyph lookup; lowercase b and d keep them distinct from 8 and 0.
  always_comb begin
    glyph_n = 7'h7F;
    case (IN)
      4'h0:    glyph_n = 7'h40;
      4'h1:    glyph_n = 7'h79;
      4'h2:    glyph_n = 7'h24;
      4'h3:    glyph_n = 7'h30;
      4'h4:    glyph_n = 7'h19;
      4'h5:    glyph_n = 7'h12;
      4'h6:    glyph_n = 7'h02;
      4'h7:    glyph_n = 7'h78;
      4'h8:    glyph_n = 7'h00;
      4'h9:    glyph_n = 7'h10;
      4'hA:    glyph_n = 7'h08;
      4'hB:    glyph_n = 7'h03;
      4'hC:    glyph_n = 7'h46;
      4'hD:    glyph_n = 7'h21;
      4'hE:    glyph_n = 7'h06;
      4'hF:    glyph_n = 7'h0E;
      default: glyph_n = 7'h7F;
    endcase
  end

  // Override priority: lamp test over blank over normal decode.
  always_comb begin
    out_d = ACTIVE_LOW ? glyph_n : ~glyph_n;
    if (I_BLANK) begin
      out_d = AllDark;
    end
    if (I_LAMP_TEST) begin
      out_d = AllLit;
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      out_q <= AllDark;
    end else begin
      out_q <= out_d;
    end
  end

  assign OUT = out_q;

endmodule

// File: tb/tb_seven_seg_decoder.sv
// Bench for seven_seg_decoder: directed vector table plus randomized run
// against a segment-letter reference model. Both polarities are exercised.

module tb_seven_seg_decoder;

  logic       clk;
  logic       rst;
  logic [3:0] nib;
  logic       blank;
  logic       lamp;
  logic [6:0] out_lo;
  logic [6:0] out_hi;

  int checks;
  int errors;

  seven_seg_decoder #(.ACTIVE_LOW(1'b1)) u_dut_lo (
    .I_CLK       (clk),
    .I_RST       (rst),
    .IN          (nib),
    .I_BLANK     (blank),
    .I_LAMP_TEST (lamp),
    .OUT         (out_lo)
  );

  seven_seg_decoder #(.ACTIVE_LOW(1'b0)) u_dut_hi (
    .I_CLK       (clk),
    .I_RST       (rst),
    .IN          (nib),
    .I_BLANK     (blank),
    .I_LAMP_TEST (lamp),
    .OUT         (out_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic       blank;
    logic       lamp;
    logic [3:0] nib;
    logic [6:0] exp_lo;  // expected OUT of the active-low instance
  } vec_t;

  vec_t vecs[$];

  // Lit segments of each glyph, spelled with segment letters a..g.
  string lit_segs[16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                          "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg",
                          "aefg"};

  // Reference: which segments are lit, then apply the polarity.
  function automatic logic [6:0] model(input logic r, input logic bl, input logic lt,
                                       input logic [3:0] n, input logic act_low);
    logic [6:0] lit;
    string      s;
    lit = 7'h00;
    s   = lit_segs[n];
    for (int i = 0; i < s.len(); i++) begin
      lit[s[i] - "a"] = 1'b1;
    end
    if (r)        lit = 7'h00;
    else if (lt)  lit = 7'h7F;
    else if (bl)  lit = 7'h00;
    return act_low ? ~lit : lit;
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs and sample both outputs just after the edge.
  task automatic step(input logic r, input logic bl, input logic lt, input logic [3:0] n);
    rst   = r;
    blank = bl;
    lamp  = lt;
    nib   = n;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic bl, input logic lt, input logic [3:0] n,
                     input logic [6:0] e);
    vec_t v;
    v.rst    = r;
    v.blank  = bl;
    v.lamp   = lt;
    v.nib    = n;
    v.exp_lo = e;
    vecs.push_back(v);
  endtask

  logic [6:0] sweep_exp[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    blank  = 1'b0;
    lamp   = 1'b0;
    nib    = 4'h8;
    #2;

    // Reset held two cycles with IN=8, then release.
    add(1'b1, 1'b0, 1'b0, 4'h8, 7'h7F);
    add(1'b1, 1'b0, 1'b0, 4'h8, 7'h7F);
    add(1'b0, 1'b0, 1'b0, 4'h8, 7'h00);
    // Full sweep.
    for (int i = 0; i < 16; i++) add(1'b0, 1'b0, 1'b0, 4'(i), sweep_exp[i]);
    // Blank / lamp-test priority.
    add(1'b0, 1'b1, 1'b0, 4'h1, 7'h7F);
    add(1'b0, 1'b1, 1'b1, 4'h1, 7'h00);
    add(1'b0, 1'b0, 1'b0, 4'h1, 7'h79);
    add(1'b0, 1'b0, 1'b1, 4'h5, 7'h00);
    // Mid-operation reset beats lamp test and decode.
    add(1'b0, 1'b0, 1'b0, 4'h0, 7'h40);
    add(1'b1, 1'b0, 1'b1, 4'h1, 7'h7F);
    add(1'b0, 1'b0, 1'b0, 4'h0, 7'h40);
    add(1'b0, 1'b0, 1'b0, 4'h1, 7'h79);
    // GPU-style single-bit toggling.
    for (int i = 0; i < 4; i++) add(1'b0, 1'b0, 1'b0, {3'b000, 1'(i)}, (i % 2) ? 7'h79 : 7'h40);

    foreach (vecs[k]) begin
      step(vecs[k].rst, vecs[k].blank, vecs[k].lamp, vecs[k].nib);
      check($sformatf("vec%0d_lo", k), out_lo, vecs[k].exp_lo);
      check($sformatf("vec%0d_hi", k), out_hi, ~vecs[k].exp_lo);
    end

    // Explicit active-high spot checks.
    step(1'b1, 1'b0, 1'b0, 4'h3);
    check("hi_reset", out_hi, 7'h00);
    step(1'b0, 1'b0, 1'b0, 4'h0);
    check("hi_zero", out_hi, 7'h3F);
    step(1'b0, 1'b0, 1'b0, 4'h1);
    check("hi_one", out_hi, 7'h06);
    step(1'b0, 1'b0, 1'b1, 4'h1);
    check("hi_lamp", out_hi, 7'h7F);

    // Randomized run against the reference model.
    for (int i = 0; i < 300; i++) begin
      logic       r, bl, lt;
      logic [3:0] n;
      r  = ($urandom_range(0, 15) == 0);
      bl = ($urandom_range(0, 5) == 0);
      lt = ($urandom_range(0, 7) == 0);
      n  = 4'($urandom);
      step(r, bl, lt, n);
      check($sformatf("rnd%0d_lo", i), out_lo, model(r, bl, lt, n, 1'b1));
      check($sformatf("rnd%0d_hi", i), out_hi, model(r, bl, lt, n, 1'b0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_seg_decoder.md
Name: seven_seg_decoder

Overview:
- Registered hex-to-7-segment decoder. Converts a 4-bit nibble into a 7-bit segment pattern for one HEX digit on the board.
- The GPU instantiates four of these to show status/counter bits on HEX0..HEX3, typically with IN = {3'b0, bit}.
- Includes blanking and lamp-test overrides plus a selectable output polarity.

Parameters:
- ACTIVE_LOW, 1, 1 = segment lit when its bit is 0 (board convention); 0 = segment lit when its bit is 1.

Ports:
- I_CLK  input  1  system clock; all state updates on rising edge.
- I_RST  input  1  synchronous reset, active-high.
- IN  input  4  hex nibble to display, 0x0..0xF.
- I_BLANK  input  1  1 = all segments dark.
- I_LAMP_TEST  input  1  1 = all segments lit.
- OUT  output  7  segment drive. OUT[0]=a, [1]=b, [2]=c, [3]=d, [4]=e, [5]=f, [6]=g.

Behaviour:
- One clock only. Single output register OUT. No combinational path from any input to OUT.
- Reset: when I_RST=1 at a rising edge, OUT loads the "all dark" pattern.
  - All dark = 7'h7F when ACTIVE_LOW=1; 7'h00 when ACTIVE_LOW=0.
  - Reset has priority over every other input. Asserting reset mid-operation blanks the digit on the next edge.
- Latency: exactly 1 cycle. OUT at edge N+1 reflects IN, I_BLANK and I_LAMP_TEST sampled at edge N.
- Priority per cycle, highest first: I_RST, I_LAMP_TEST, I_BLANK, normal decode.
  - I_LAMP_TEST=1 gives all lit: 7'h00 when active-low, 7'h7F when active-high.
  - I_LAMP_TEST=1 with I_BLANK=1 still gives all lit.
- Decode table, written as ACTIVE_LOW=1 patterns, bits g..a (OUT[6:0]):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- ACTIVE_LOW=0: the result is the bitwise inverse of the table entry. The same inversion applies to the dark and lit patterns.
- All 16 input codes are defined. No X propagation. Lowercase b and d glyphs are used so they are distinct from 8 and 0.
- Arithmetic: none. Pure lookup followed by the polarity mux and the register.
- IN may change every cycle; each value is reflected one cycle later with no hold-off or handshake.

Test Plan:
- Reset: I_RST=1 for 2 cycles with IN=4'h8 -> OUT=7'h7F during reset and on the first edge after release. The next edge gives OUT=7'h00.
- Full sweep: release reset, drive IN=0..F one per cycle -> OUT one cycle later follows 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E in order.
- Blank/lamp-test priority:
  - IN=4'h1, I_BLANK=1 -> OUT=7'h7F.
  - Then also I_LAMP_TEST=1 -> OUT=7'h00.
  - Drop both -> OUT=7'h79 after 1 cycle.
- Mid-operation reset: alternate IN=0/1 each cycle, assert I_RST for one cycle -> the next edge gives 7'h7F regardless of IN, then decode resumes on the following cycle.
- Polarity: ACTIVE_LOW=0 instance.
  - Reset -> 7'h00.
  - IN=4'h0 -> 7'h3F; IN=4'h1 -> 7'h06.
  - Lamp test -> 7'h7F.
- GPU-style use: IN={3'b0,bit} toggling 0/1 -> OUT alternates 7'h40 / 7'h79 with 1-cycle lag.
